// File: rtl/psa_pkg.sv
// psa_pkg: shared definitions for the PSA search engine.
//   - default width / latency constants used as parameter defaults
//   - FSM state encoding
//   - saturating increment helper for the match counter
package psa_pkg;

  localparam int DW_DEF     = 8;
  localparam int AW_DEF     = 8;
  localparam int LW_DEF     = 8;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } psa_state_t;

  // Increment that sticks at i_max; callers pass their field's all-ones value.
  function automatic logic [31:0] sat_inc(input logic [31:0] i_val,
                                          input logic [31:0] i_max);
    return (i_val >= i_max) ? i_max : i_val + 32'd1;
  endfunction

endpackage

// File: rtl/psa_search_engine_if.sv
// psa_search_engine_if: match result stream (valid/ready).
//   match_valid : engine -> consumer, match_addr is valid
//   match_ready : consumer -> engine, accepts the match on a clock edge
//   match_addr  : absolute data address of the match start
// Modports: master (engine side), slave (consumer side).
interface psa_search_engine_if #(
  parameter int AW = 8
);
  logic          match_valid;
  logic          match_ready;
  logic [AW-1:0] match_addr;

  modport master (output match_valid, output match_addr, input match_ready);
  modport slave  (input match_valid, input match_addr, output match_ready);
endinterface

// File: rtl/psa_rd_wait.sv
// psa_rd_wait: BRAM read-latency timer.
//   CLK100MHZ, reset  : clock, async active-high reset
//   i_load            : reload the down-counter with RD_LAT (FSM in ISSUE)
//   i_en              : count enable (FSM in WAIT)
//   o_tc              : terminal count, last WAIT cycle
//   o_data_valid      : registered, high in the cycle after o_tc (CMP)
module psa_rd_wait
  import psa_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc,
  output logic o_data_valid
);

  logic [2:0] r_cnt;
  logic       r_data_valid;

  // Counter holds RD_LAT on the first WAIT cycle, so reaching 1 marks the
  // last of exactly RD_LAT wait cycles.
  assign o_tc         = i_en && (r_cnt == 3'd1);
  assign o_data_valid = r_data_valid;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_cnt        <= 3'd0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= o_tc;
      if (i_load)
        r_cnt <= 3'(RD_LAT);
      else if (i_en && (r_cnt != 3'd0))
        r_cnt <= r_cnt - 3'd1;
    end
  end

endmodule

// File: rtl/psa_search_engine.sv
// psa_search_engine: scans a data BRAM block for every occurrence of a
// pattern held in a pattern BRAM (naive backtracking) and streams each match
// start address over a valid/ready interface.
// Ports:
//   CLK100MHZ, reset        : clock, async active-high reset
//   start                   : pulse, latches bases/lengths (ignored while busy)
//   p_base, p_len           : pattern address / length
//   b_base, b_len           : data block address / length
//   mem_addr, mem_dout      : data BRAM address (registered) / read data
//   pat_addr, pat_dout      : pattern BRAM address (registered) / read data
//   m_if (master)           : match_valid / match_ready / match_addr
//   match_count             : matches emitted this search, saturating
//   busy, done              : search in progress / complete (sticky)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_ISSUE | register data/pattern addresses for byte (i, k)
// S_WAIT  | RD_LAT cycles of BRAM read latency
// S_CMP   | compare data byte against pattern byte
// S_EMIT  | match presented, stalled until match_ready
// S_DONE  | search finished, done held; start re-arms
module psa_search_engine
  import psa_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int LW      = LW_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int OVERLAP = 1
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AW-1:0]          p_base,
  input  logic [LW-1:0]          p_len,
  input  logic [AW-1:0]          b_base,
  input  logic [LW-1:0]          b_len,
  output logic [AW-1:0]          mem_addr,
  input  logic [DW-1:0]          mem_dout,
  output logic [AW-1:0]          pat_addr,
  input  logic [DW-1:0]          pat_dout,
  psa_search_engine_if.master    m_if,
  output logic [LW-1:0]          match_count,
  output logic                   busy,
  output logic                   done
);

  typedef logic [LW:0] ext_t;
  localparam logic [LW-1:0] CNT_MAX = '1;

  psa_state_t    r_state;
  logic [AW-1:0] r_p_base;
  logic [AW-1:0] r_b_base;
  logic [LW-1:0] r_p_len;
  ext_t          r_bound;
  logic [LW-1:0] r_i;
  logic [LW-1:0] r_k;
  logic [AW-1:0] r_mem_addr;
  logic [AW-1:0] r_pat_addr;
  logic [AW-1:0] r_match_addr;
  logic          r_match_valid;
  logic [LW-1:0] r_match_count;
  logic          r_busy;
  logic          r_done;

  logic          w_tc;
  logic          w_data_valid;
  logic          w_start_ok;
  logic          w_last_k;
  ext_t          w_i_miss;
  ext_t          w_i_emit;

  // Bound and next-candidate values carry one extra bit so that
  // p_len > b_len and i stepping past the end never wrap around.
  assign w_start_ok = (p_len != '0) && (p_len <= b_len);
  assign w_last_k   = (r_k == (r_p_len - LW'(1)));
  assign w_i_miss   = ext_t'(r_i) + ext_t'(1);
  assign w_i_emit   = ext_t'(r_i) + ((OVERLAP != 0) ? ext_t'(1) : ext_t'(r_p_len));

  psa_rd_wait #(
    .RD_LAT (RD_LAT)
  ) u_rd_wait (
    .CLK100MHZ    (CLK100MHZ),
    .reset        (reset),
    .i_load       (r_state == S_ISSUE),
    .i_en         (r_state == S_WAIT),
    .o_tc         (w_tc),
    .o_data_valid (w_data_valid)
  );

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_p_base      <= '0;
      r_b_base      <= '0;
      r_p_len       <= '0;
      r_bound       <= '0;
      r_i           <= '0;
      r_k           <= '0;
      r_mem_addr    <= '0;
      r_pat_addr    <= '0;
      r_match_addr  <= '0;
      r_match_valid <= 1'b0;
      r_match_count <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_p_base      <= p_base;
            r_b_base      <= b_base;
            r_p_len       <= p_len;
            r_bound       <= ext_t'(b_len) - ext_t'(p_len);
            r_i           <= '0;
            r_k           <= '0;
            r_match_count <= '0;
            if (w_start_ok) begin
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end

        S_ISSUE: begin
          r_mem_addr <= r_b_base + AW'(r_i) + AW'(r_k);
          r_pat_addr <= r_p_base + AW'(r_k);
          r_state    <= S_WAIT;
        end

        S_WAIT: begin
          if (w_tc)
            r_state <= S_CMP;
        end

        S_CMP: begin
          if (w_data_valid) begin
            if (mem_dout == pat_dout) begin
              if (w_last_k) begin
                r_match_addr  <= r_b_base + AW'(r_i);
                r_match_valid <= 1'b1;
                r_state       <= S_EMIT;
              end else begin
                r_k     <= r_k + LW'(1);
                r_state <= S_ISSUE;
              end
            end else begin
              r_k <= '0;
              r_i <= LW'(w_i_miss);
              if (w_i_miss > r_bound) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_state <= S_ISSUE;
              end
            end
          end
        end

        S_EMIT: begin
          if (m_if.match_ready) begin
            r_match_valid <= 1'b0;
            r_match_count <= LW'(sat_inc(32'(r_match_count), 32'(CNT_MAX)));
            r_k           <= '0;
            r_i           <= LW'(w_i_emit);
            if (w_i_emit > r_bound) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr         = r_mem_addr;
  assign pat_addr         = r_pat_addr;
  assign m_if.match_valid = r_match_valid;
  assign m_if.match_addr  = r_match_addr;
  assign match_count      = r_match_count;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule

// File: tb/tb_psa_search_engine.sv
// tb_psa_search_engine: directed bench for psa_search_engine.
// Two engines share behavioural 2-cycle-latency BRAM models: u_a runs with
// OVERLAP=1, u_b with OVERLAP=0. Accepted matches are logged into queues.
module tb_psa_search_engine;

  logic CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  logic       reset;
  logic       a_start, b_start;
  logic [7:0] p_base, p_len, b_base, b_len;
  logic [7:0] dmem [256];
  logic [7:0] pmem [256];

  logic [7:0] a_mem_addr, a_pat_addr, a_mem_dout, a_pat_dout, a_d1, a_q1, a_count;
  logic [7:0] b_mem_addr, b_pat_addr, b_mem_dout, b_pat_dout, b_d1, b_q1, b_count;
  logic       a_busy, a_done, b_busy, b_done;

  psa_search_engine_if #(.AW(8)) a_if ();
  psa_search_engine_if #(.AW(8)) b_if ();

  psa_search_engine #(.DW(8), .AW(8), .LW(8), .RD_LAT(2), .OVERLAP(1)) u_a (
    .CLK100MHZ (CLK100MHZ), .reset (reset), .start (a_start),
    .p_base (p_base), .p_len (p_len), .b_base (b_base), .b_len (b_len),
    .mem_addr (a_mem_addr), .mem_dout (a_mem_dout),
    .pat_addr (a_pat_addr), .pat_dout (a_pat_dout),
    .m_if (a_if), .match_count (a_count), .busy (a_busy), .done (a_done)
  );

  psa_search_engine #(.DW(8), .AW(8), .LW(8), .RD_LAT(2), .OVERLAP(0)) u_b (
    .CLK100MHZ (CLK100MHZ), .reset (reset), .start (b_start),
    .p_base (p_base), .p_len (p_len), .b_base (b_base), .b_len (b_len),
    .mem_addr (b_mem_addr), .mem_dout (b_mem_dout),
    .pat_addr (b_pat_addr), .pat_dout (b_pat_dout),
    .m_if (b_if), .match_count (b_count), .busy (b_busy), .done (b_done)
  );

  always @(posedge CLK100MHZ) begin
    a_d1 <= dmem[a_mem_addr]; a_mem_dout <= a_d1;
    a_q1 <= pmem[a_pat_addr]; a_pat_dout <= a_q1;
    b_d1 <= dmem[b_mem_addr]; b_mem_dout <= b_d1;
    b_q1 <= pmem[b_pat_addr]; b_pat_dout <= b_q1;
  end

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] la[$];
  logic [7:0] la_last;
  logic       la_en;

  always @(posedge CLK100MHZ) begin
    if (a_if.match_valid && a_if.match_ready) qa.push_back(a_if.match_addr);
    if (b_if.match_valid && b_if.match_ready) qb.push_back(b_if.match_addr);
    if (!la_en) la_last = a_mem_addr;
    else if (a_mem_addr != la_last) begin
      la.push_back(a_mem_addr);
      la_last = a_mem_addr;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a();
    @(negedge CLK100MHZ) a_start = 1'b1;
    @(negedge CLK100MHZ) a_start = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge CLK100MHZ) b_start = 1'b1;
    @(negedge CLK100MHZ) b_start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!a_done && n < 1000) begin
      @(negedge CLK100MHZ);
      n++;
    end
    chk({tag, "_done"}, 32'(a_done), 1);
    chk({tag, "_busy"}, 32'(a_busy), 0);
  endtask

  task automatic wait_done_b(input string tag);
    int n = 0;
    while (!b_done && n < 1000) begin
      @(negedge CLK100MHZ);
      n++;
    end
    chk({tag, "_done"}, 32'(b_done), 1);
    chk({tag, "_busy"}, 32'(b_busy), 0);
  endtask

  task automatic setup_abab();
    for (int j = 0; j < 8; j++) dmem[8'h10 + j] = (j % 2 == 0) ? "A" : "B";
    pmem[8'h20] = "A"; pmem[8'h21] = "B"; pmem[8'h22] = "A";
    p_base = 8'h20; p_len = 8'd3; b_base = 8'h10; b_len = 8'd8;
  endtask

  initial begin
    reset = 1'b1; a_start = 1'b0; b_start = 1'b0; la_en = 1'b0;
    a_if.match_ready = 1'b1; b_if.match_ready = 1'b1;
    p_base = '0; p_len = '0; b_base = '0; b_len = '0;
    for (int j = 0; j < 256; j++) begin dmem[j] = 8'h00; pmem[j] = 8'h00; end

    // Reset state
    @(negedge CLK100MHZ);
    @(negedge CLK100MHZ);
    chk("rst_mem_addr", 32'(a_mem_addr), 0);
    chk("rst_pat_addr", 32'(a_pat_addr), 0);
    chk("rst_valid", 32'(a_if.match_valid), 0);
    chk("rst_match_addr", 32'(a_if.match_addr), 0);
    chk("rst_count", 32'(a_count), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_b_done", 32'(b_done), 0);
    reset = 1'b0;

    // ABABABAB / ABA, overlapping
    setup_abab();
    qa.delete();
    pulse_a();
    chk("ov_busy_start", 32'(a_busy), 1);
    wait_done_a("ov");
    chk("ov_nmatch", 32'(qa.size()), 3);
    chk("ov_m0", 32'(qa[0]), 32'h10);
    chk("ov_m1", 32'(qa[1]), 32'h12);
    chk("ov_m2", 32'(qa[2]), 32'h14);
    chk("ov_count", 32'(a_count), 3);

    // Same, non-overlapping
    qb.delete();
    pulse_b();
    wait_done_b("nov");
    chk("nov_nmatch", 32'(qb.size()), 2);
    chk("nov_m0", 32'(qb[0]), 32'h10);
    chk("nov_m1", 32'(qb[1]), 32'h14);
    chk("nov_count", 32'(b_count), 2);

    // Backtrack: AAB / AB
    dmem[8'h00] = "A"; dmem[8'h01] = "A"; dmem[8'h02] = "B";
    pmem[8'h30] = "A"; pmem[8'h31] = "B";
    p_base = 8'h30; p_len = 8'd2; b_base = 8'h00; b_len = 8'd3;
    qa.delete();
    pulse_a();
    wait_done_a("bt");
    chk("bt_nmatch", 32'(qa.size()), 1);
    chk("bt_m0", 32'(qa[0]), 32'h01);
    chk("bt_count", 32'(a_count), 1);
    chk("bt_last_mem_addr", 32'(a_mem_addr), 32'h02);
    chk("bt_last_pat_addr", 32'(a_pat_addr), 32'h31);

    // p_len > b_len: immediate done, no reads
    p_len = 8'd4; b_len = 8'd3;
    qa.delete();
    pulse_a();
    chk("big_done", 32'(a_done), 1);
    chk("big_busy", 32'(a_busy), 0);
    chk("big_count_clr", 32'(a_count), 0);
    @(negedge CLK100MHZ);
    chk("big_mem_addr", 32'(a_mem_addr), 32'h02);
    chk("big_valid", 32'(a_if.match_valid), 0);
    chk("big_nmatch", 32'(qa.size()), 0);

    // p_len == 0 on the non-overlap engine
    p_len = 8'd0; b_len = 8'd8;
    qb.delete();
    pulse_b();
    chk("zero_done", 32'(b_done), 1);
    chk("zero_busy", 32'(b_busy), 0);
    chk("zero_count_clr", 32'(b_count), 0);
    @(negedge CLK100MHZ);
    chk("zero_mem_addr", 32'(b_mem_addr), 32'h16);
    chk("zero_nmatch", 32'(qb.size()), 0);

    // Backpressure on the first match
    setup_abab();
    a_if.match_ready = 1'b0;
    qa.delete();
    pulse_a();
    begin
      int n = 0;
      while (!a_if.match_valid && n < 1000) begin
        @(negedge CLK100MHZ);
        n++;
      end
    end
    chk("bp_valid_seen", 32'(a_if.match_valid), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK100MHZ);
      chk("bp_valid_hold", 32'(a_if.match_valid), 1);
      chk("bp_addr_hold", 32'(a_if.match_addr), 32'h10);
      chk("bp_mem_addr_hold", 32'(a_mem_addr), 32'h12);
      chk("bp_pat_addr_hold", 32'(a_pat_addr), 32'h22);
    end
    chk("bp_no_accept", 32'(qa.size()), 0);
    a_if.match_ready = 1'b1;
    wait_done_a("bp");
    chk("bp_nmatch", 32'(qa.size()), 3);
    chk("bp_m0", 32'(qa[0]), 32'h10);
    chk("bp_m1", 32'(qa[1]), 32'h12);
    chk("bp_m2", 32'(qa[2]), 32'h14);
    chk("bp_count", 32'(a_count), 3);

    // Address wrap at the top of memory
    dmem[8'hFE] = "X"; dmem[8'hFF] = "Y"; dmem[8'h00] = "Z"; dmem[8'h01] = "W";
    pmem[8'h40] = "X"; pmem[8'h41] = "Y"; pmem[8'h42] = "Z"; pmem[8'h43] = "W";
    p_base = 8'h40; p_len = 8'd4; b_base = 8'hFE; b_len = 8'd4;
    qa.delete(); la.delete();
    @(negedge CLK100MHZ) la_en = 1'b1;
    pulse_a();
    wait_done_a("wrap");
    la_en = 1'b0;
    chk("wrap_nreads", 32'(la.size()), 4);
    chk("wrap_rd0", 32'(la[0]), 32'hFE);
    chk("wrap_rd1", 32'(la[1]), 32'hFF);
    chk("wrap_rd2", 32'(la[2]), 32'h00);
    chk("wrap_rd3", 32'(la[3]), 32'h01);
    chk("wrap_nmatch", 32'(qa.size()), 1);
    chk("wrap_m0", 32'(qa[0]), 32'hFE);
    chk("wrap_pat_addr", 32'(a_pat_addr), 32'h43);

    // Reset mid-search, then rescan from the start
    setup_abab();
    qa.delete();
    pulse_a();
    repeat (6) @(negedge CLK100MHZ);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_addr", 32'(a_mem_addr), 0);
    chk("abort_pat_addr", 32'(a_pat_addr), 0);
    chk("abort_valid", 32'(a_if.match_valid), 0);
    chk("abort_match_addr", 32'(a_if.match_addr), 0);
    chk("abort_count", 32'(a_count), 0);
    chk("abort_busy", 32'(a_busy), 0);
    chk("abort_done", 32'(a_done), 0);
    @(negedge CLK100MHZ) reset = 1'b0;
    chk("abort_no_partial", 32'(qa.size()), 0);
    la.delete();
    la_en = 1'b1;
    pulse_a();
    wait_done_a("rescan");
    la_en = 1'b0;
    chk("rescan_first_rd", 32'(la[0]), 32'h10);
    chk("rescan_nmatch", 32'(qa.size()), 3);
    chk("rescan_m0", 32'(qa[0]), 32'h10);
    chk("rescan_m2", 32'(qa[2]), 32'h14);
    chk("rescan_count", 32'(a_count), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psa_search_engine.md
Name: psa_search_engine

Overview:
Parametrised successor to the single-result PSA search block. It scans a block of data BRAM for every occurrence of a pattern held in pattern BRAM, using correct naive backtracking. Each match start address is streamed out over a valid/ready handshake. Widths, BRAM read latency and overlap mode are parameters. The BRAMs are instantiated outside the block; the engine drives their address ports and reads their data outputs.

Parameters:
DW, 8, data/pattern byte width in bits
AW, 8, address width of both BRAMs; all address arithmetic is modulo 2^AW
LW, 8, width of the p_len, b_len and match_count fields
RD_LAT, 2, BRAM read latency in cycles (1..7)
OVERLAP, 1, 1 = resume the scan at start+1 after a match; 0 = resume at start+p_len

Ports:
CLK100MHZ  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse; latches the bases/lengths and begins a search (ignored while busy)
p_base  in  AW  pattern start address
p_len  in  LW  pattern length
b_base  in  AW  data block start address
b_len  in  LW  data block length
mem_addr  out  AW  data BRAM address (registered)
mem_dout  in  DW  data BRAM read data
pat_addr  out  AW  pattern BRAM address (registered)
pat_dout  in  DW  pattern BRAM read data
match_valid  out  1  match_addr holds a valid match
match_ready  in  1  consumer accepts the match
match_addr  out  AW  absolute data address where the match starts
match_count  out  LW  matches emitted this search; saturates at all-ones
busy  out  1  search in progress
done  out  1  search complete; held until the next start or reset

Behaviour:
- Reset (async): state IDLE. All outputs 0: mem_addr, pat_addr, match_valid, match_addr, match_count, busy, done. Internal counters i=0, k=0. A reset mid-search aborts it; no partial match is emitted.
- States and transitions:
  - IDLE: on start, latch the inputs, clear done and match_count, set busy.
    - If p_len==0 or p_len>b_len: go to DONE with no reads.
    - Otherwise set i=0, k=0 and go to ISSUE.
  - ISSUE: register mem_addr=b_base+i+k and pat_addr=p_base+k (wrap modulo 2^AW). Go to WAIT.
  - WAIT: stay exactly RD_LAT cycles, then go to CMP. Both addresses are held constant from ISSUE through CMP.
  - CMP: compare mem_dout with pat_dout.
    - Equal and k<p_len-1: k++, go to ISSUE.
    - Equal and k==p_len-1: load match_addr=b_base+i, set match_valid, go to EMIT.
    - Not equal: k=0, i++ (backtrack to the next candidate start).
    - After the i++: if i>b_len-p_len go to DONE, else go to ISSUE.
  - EMIT: hold match_valid, match_addr and both addresses stable until match_ready is high on a clock edge. On that edge:
    - clear match_valid and increment match_count (saturating);
    - set i += (OVERLAP ? 1 : p_len) and k=0;
    - if i>b_len-p_len go to DONE, else go to ISSUE.
  - DONE: done=1, busy=0. On a new start, behave as IDLE+start in the same cycle.
- Timing: one byte comparison takes RD_LAT+2 cycles, ISSUE through CMP inclusive. A match is visible on match_valid the cycle after the final CMP.
- Backpressure: the engine is fully stalled in EMIT. There is no match buffering, and no match is dropped.
- Width rules:
  - i and k are LW bits wide.
  - The bound b_len-p_len is computed in LW+1 bits, so p_len>b_len never wraps.
  - Address adds truncate to AW bits, so a block crossing the top of memory wraps to 0.
- Simultaneous events:
  - start while busy: ignored.
  - reset together with start: reset wins.
  - match_ready with no match_valid: no effect.

Decomposition:
- Shared package psa_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, CMP, EMIT, DONE);
  - default parameter constants (DW, AW, LW, RD_LAT);
  - the saturating-increment function.
- One natural sub-module, psa_rd_wait: a loadable down-counter that generates the RD_LAT wait and pulses a "data valid" signal into CMP.
- The remaining FSM and datapath stay flat.

Test Plan:
- Data "ABABABAB" at b_base=0x10, b_len=8; pattern "ABA", p_len=3; OVERLAP=1 -> matches 0x10, 0x12, 0x14 in order; match_count=3; done=1.
- Same stimulus with OVERLAP=0 -> matches 0x10, 0x14; match_count=2.
- Backtrack case: data "AAB" at 0x00, b_len=3; pattern "AB" -> a single match at 0x01 (must not be missed after the partial match at 0x00).
- Boundaries:
  - p_len=4, b_len=3 -> done within 2 cycles, no match_valid, mem_addr unchanged.
  - p_len=0 -> same response.
- Backpressure: hold match_ready low for 10 cycles on the first match -> match_valid and match_addr stable, mem_addr/pat_addr frozen, no lost matches afterwards.
- Wrap and abort:
  - b_base=0xFE, b_len=4 -> reads occur at 0xFE, 0xFF, 0x00, 0x01.
  - reset asserted mid-search -> all outputs 0 immediately; a subsequent start rescans from i=0.
